dot_product_engine: RTL

DOT_PRODUCT_ENGINE -- requirements
Module: dot_product_engine

---
 rtl/dot_product_engine.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dot_product_engine.sv
// Sequential 16-element dot product of 2-bit signed weights and 8-bit unsigned
// activations, one element per clock, with ReLU/saturating 8-bit output.
module dot_product_engine #(
    parameter int OUT_SHIFT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [31:0]  weights,
    input  logic [127:0] data,
    output logic         busy,
    output logic         done,
    output logic [7:0]   result
);

    // state | meaning
    // IDLE  | waiting for start; operands not captured
    // RUN   | one element accumulated per edge, idx 0..15
    // DONE  | one-cycle result-valid pulse, then back to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         weights_q, weights_d;
    logic [127:0]        data_q, data_d;
    logic signed [13:0]  acc_q, acc_d;
    logic [3:0]          idx_q, idx_d;
    logic [7:0]          result_q, result_d;

    logic [7:0]          d_cur;
    logic [1:0]          w_cur;
    logic signed [9:0]   d_ext;
    logic signed [9:0]   w_ext;
    logic signed [9:0]   prod;
    logic signed [13:0]  sum;
    logic signed [13:0]  shifted;
    logic [7:0]          clamped;

    always_comb begin
        d_cur   = data_q[{idx_q, 3'b000} +: 8];
        w_cur   = weights_q[{idx_q, 1'b0} +: 2];
        d_ext   = {2'b00, d_cur};
        w_ext   = {{8{w_cur[1]}}, w_cur};
        // |prod| <= 510, so the 10-bit product is exact
        prod    = d_ext * w_ext;
        sum     = acc_q + {{4{prod[9]}}, prod};
        shifted = sum >>> OUT_SHIFT;
        if (shifted[13]) begin
            clamped = 8'd0;
        end else if (shifted > 14'sd255) begin
            clamped = 8'hFF;
        end else begin
            clamped = shifted[7:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        weights_d = weights_q;
        data_d    = data_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        result_d  = result_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    weights_d = weights;
                    data_d    = data;
                    acc_d     = '0;
                    idx_d     = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // abort wins even on the final element
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    acc_d = sum;
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        result_d = clamped;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            weights_q <= '0;
            data_q    <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            weights_q <= weights_d;
            data_q    <= data_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            result_q  <= result_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule
